// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants and colour-bar table.
// Shared by vga_timing_gen and vga_axis_counter.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int N_BARS = 8;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    unique case (idx)
      3'd0: c = COL_WHITE;
      3'd1: c = COL_YELLOW;
      3'd2: c = COL_CYAN;
      3'd3: c = COL_GREEN;
      3'd4: c = COL_MAGENTA;
      3'd5: c = COL_RED;
      3'd6: c = COL_BLUE;
      3'd7: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis -- position counter, wrap,
// sync/active decode and active-relative coordinate.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  output logic         wrap,
  output logic         in_sync,
  output logic         active,
  output logic         first,
  output logic [W-1:0] coord
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam int A_LO  = SYNC + BACK;
  localparam int A_HI  = TOTAL - FRONT;

  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
  localparam logic [W-1:0] S_END = W'(SYNC);
  localparam logic [W-1:0] LO    = W'(A_LO);
  localparam logic [W-1:0] HI    = W'(A_HI);
  localparam logic [W-1:0] OUTS  = W'(ACTIVE);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap    = (cnt_q == LAST);
  assign in_sync = (cnt_q < S_END);
  assign active  = (cnt_q >= LO) && (cnt_q < HI);
  assign first   = (cnt_q == LO);
  assign coord   = active ? (cnt_q - LO) : OUTS;

  // advance on request, wrapping at the end of the axis
  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel-enable stall.
// Optional colour-bar output rgb_pat under macro VGA_TIMING_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   FCNT_W   = 16,
  localparam int  H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int  XW       = $clog2(H_TOTAL),
  localparam int  YW       = $clog2(V_TOTAL)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              pix_en,
  output logic              HS,
  output logic              VS,
  output logic              BLANK_n,
  output logic [XW-1:0]     CoorX,
  output logic [YW-1:0]     CoorY,
  output logic              sol,
  output logic              sof,
  output logic [FCNT_W-1:0] frame_cnt
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [23:0]       rgb_pat
`endif
);

  logic          h_wrap, h_sync, h_act, h_first;
  logic          v_wrap, v_sync, v_act, v_first;
  logic [XW-1:0] h_coord;
  logic [YW-1:0] v_coord;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT),
    .SYNC(H_SYNC), .BACK(H_BACK), .W(XW)
  ) u_h (
    .clk(vga_clk), .rst_n(reset_n), .adv(pix_en),
    .wrap(h_wrap), .in_sync(h_sync), .active(h_act),
    .first(h_first), .coord(h_coord)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT),
    .SYNC(V_SYNC), .BACK(V_BACK), .W(YW)
  ) u_v (
    .clk(vga_clk), .rst_n(reset_n), .adv(pix_en & h_wrap),
    .wrap(v_wrap), .in_sync(v_sync), .active(v_act),
    .first(v_first), .coord(v_coord)
  );

  logic              hs_q, hs_d, vs_q, vs_d;
  logic              blank_q, blank_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              sol_q, sol_d, sof_q, sof_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // register outputs from the current position; hold on stall
  always_comb begin
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    x_d     = x_q;
    y_d     = y_q;
    sol_d   = 1'b0;
    sof_d   = 1'b0;
    fcnt_d  = fcnt_q;
    if (pix_en) begin
      hs_d    = h_sync ? HS_POL : ~HS_POL;
      vs_d    = v_sync ? VS_POL : ~VS_POL;
      blank_d = h_act & v_act;
      x_d     = h_coord;
      y_d     = v_coord;
      sol_d   = h_first & v_act;
      sof_d   = h_first & v_first;
      if (h_wrap && v_wrap) fcnt_d = fcnt_q + 1'b1;
    end
  end

  // output and frame-count registers
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
      x_q     <= XW'(H_ACTIVE);
      y_q     <= YW'(V_ACTIVE);
      sol_q   <= 1'b0;
      sof_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sol_q   <= sol_d;
      sof_q   <= sof_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign HS        = hs_q;
  assign VS        = vs_q;
  assign BLANK_n   = blank_q;
  assign CoorX     = x_q;
  assign CoorY     = y_q;
  assign sol       = sol_q;
  assign sof       = sof_q;
  assign frame_cnt = fcnt_q;

`ifdef VGA_TIMING_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / N_BARS;

  logic [23:0] rgb_q, rgb_d;
  logic [2:0]  bar_idx;

  assign bar_idx = 3'(h_coord / XW'(BAR_W));

  // colour bars follow the blanking timing exactly
  always_comb begin
    rgb_d = rgb_q;
    if (pix_en) begin
      rgb_d = (h_act & v_act) ? bar_colour(bar_idx) : 24'h0;
    end
  end

  // pattern register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) rgb_q <= 24'h0;
    else          rgb_q <= rgb_d;
  end

  assign rgb_pat = rgb_q;
`endif

endmodule
